// File: rtl/siso_read_sequencer.sv
// Read-issue sequencer for the SISO row unit: walks layers/addresses per iteration.
// Optional SEQ_EARLY_TERM_EN drains after every iteration and stops on synd_ok.
module siso_read_sequencer #(
  parameter int ADDRWIDTH = 5,
  parameter int ADDRDEPTH = 20,
  parameter int LAYERS    = 2,
  parameter int ITERBITS  = 5,
  parameter int WBLAT     = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ITERBITS-1:0]  max_iter,
  input  logic                 stall,
  input  logic                 synd_ok,
  output logic                 rdlayer,
  output logic [ADDRWIDTH-1:0] rdaddress,
  output logic                 rden_LLR,
  output logic                 rden_E,
  output logic [ITERBITS-1:0]  iter_count,
  output logic                 busy,
  output logic                 done
);

  localparam int GAP = (WBLAT > ADDRDEPTH) ? WBLAT - ADDRDEPTH : 0;
  localparam int CW  = 16;

  localparam logic [CW-1:0] GAP_LAST =
    CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CW-1:0] WB_LAST =
    CW'((WBLAT > 0) ? WBLAT - 1 : 0);
  localparam logic [ADDRWIDTH-1:0] A_LAST =
    ADDRWIDTH'(ADDRDEPTH - 1);
  localparam logic L_LAST = 1'(LAYERS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]           state;
  logic [ADDRWIDTH-1:0] addr;
  logic                 layer;
  logic [ITERBITS-1:0]  iter;
  logic [ITERBITS-1:0]  max_r;
  logic [CW-1:0]        cnt;

  logic last_addr;
  logic last_layer;
  logic last_iter;
  logic end_iter;

  assign last_addr  = (addr == A_LAST);
  assign last_layer = (layer == L_LAST);
  assign last_iter  = (iter == max_r - ITERBITS'(1));
  assign end_iter   = last_addr && last_layer;

`ifndef SEQ_EARLY_TERM_EN
  logic unused_synd_ok;
  assign unused_synd_ok = synd_ok;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      layer      <= 1'b0;
      iter       <= '0;
      max_r      <= '0;
      cnt        <= '0;
      rdlayer    <= 1'b0;
      rdaddress  <= '0;
      rden_LLR   <= 1'b0;
      rden_E     <= 1'b0;
      iter_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      rden_LLR <= 1'b0;
      rden_E   <= 1'b0;
      done     <= (state == S_DONE);
      busy     <= (state != S_IDLE);
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr       <= '0;
            layer      <= 1'b0;
            iter       <= '0;
            max_r      <= max_iter;
            iter_count <= '0;
            state      <= (max_iter == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            rden_LLR   <= 1'b1;
            // E memory is empty until iteration 0 has written it
            rden_E     <= (iter != '0);
            rdlayer    <= layer;
            rdaddress  <= addr;
            iter_count <= iter;
            if (end_iter && last_iter) begin
              state <= S_DRAIN;
              cnt   <= '0;
            end
`ifdef SEQ_EARLY_TERM_EN
            else if (end_iter) begin
              state <= S_DRAIN;
              cnt   <= '0;
            end
`endif
            else begin
              addr <= last_addr ? '0 : addr + ADDRWIDTH'(1);
              if (last_addr) begin
                layer <= last_layer ? 1'b0 : layer + 1'b1;
                if (last_layer)
                  iter <= iter + ITERBITS'(1);
                if (GAP > 0) begin
                  state <= S_GAP;
                  cnt   <= '0;
                end
              end
            end
          end
        end
        S_GAP: begin
          if (!stall) begin
            if (cnt == GAP_LAST)
              state <= S_ISSUE;
            else
              cnt <= cnt + CW'(1);
          end
        end
        S_DRAIN: begin
          // writeback latency is fixed, so stall does not extend it
          if (cnt == WB_LAST) begin
`ifdef SEQ_EARLY_TERM_EN
            if (synd_ok || last_iter) begin
              state <= S_DONE;
            end else begin
              state <= S_ISSUE;
              iter  <= iter + ITERBITS'(1);
              addr  <= '0;
              layer <= 1'b0;
            end
`else
            state <= S_DONE;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
